// File: rtl/fe_redirect_ctrl_pkg.sv
// Shared front-end definitions: PC geometry, redirect FSM states and
// the packed width of a predictor training record {pc, taken, target}.
package fe_redirect_ctrl_pkg;

  localparam int          FE_DBITS      = 32;
  localparam int          FE_INSTSIZE   = 4;
  localparam logic [31:0] FE_STARTPC    = 32'h100;
  localparam int          FE_UPDQ_DEPTH = 4;
  localparam int          FE_CNT_BITS   = 32;

  // Training record: branch PC, resolved direction, resolved target.
  localparam int          FE_REC_W      = 2 * FE_DBITS + 1;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } fe_state_e;

endpackage

// File: rtl/fe_redirect_ctrl_bp_upd_fifo.sv
// Small synchronous FIFO buffering branch training records for the
// single predictor write port. Head data is read straight from the array
// so a record is presented the cycle after it is written.
module bp_upd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage array, no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fe_redirect_ctrl.sv
// Fetch next-PC sequencer: owns the fetch PC, resolves mispredicts from
// AGEX, squashes wrong-path latches, queues predictor training records
// and keeps branch/mispredict/drop perf counters.
module fe_redirect_ctrl
  import fe_redirect_ctrl_pkg::*;
#(
  parameter int          DBITS      = FE_DBITS,
  parameter int          INSTSIZE   = FE_INSTSIZE,
  parameter logic [31:0] STARTPC    = FE_STARTPC,
  parameter int          UPDQ_DEPTH = FE_UPDQ_DEPTH,
  parameter int          CNT_BITS   = FE_CNT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_de,
  input  logic                pred_hit,
  input  logic [DBITS-1:0]    pred_target,
  input  logic                agex_valid,
  input  logic [DBITS-1:0]    agex_pc,
  input  logic                agex_taken,
  input  logic [DBITS-1:0]    agex_target,
  input  logic                agex_pred_taken,
  input  logic [DBITS-1:0]    agex_pred_target,
  input  logic                upd_ready,
  output logic [DBITS-1:0]    pc_out,
  output logic                pred_taken_out,
  output logic                fe_valid_out,
  output logic                squash_out,
  output logic                upd_valid,
  output logic [DBITS-1:0]    upd_pc,
  output logic                upd_taken,
  output logic [DBITS-1:0]    upd_target,
  output logic [CNT_BITS-1:0] br_count,
  output logic [CNT_BITS-1:0] mispred_count,
  output logic [CNT_BITS-1:0] upd_drop_count
);

  localparam int REC_W = 2 * DBITS + 1;

  fe_state_e          state_q;
  logic [DBITS-1:0]   pc_q, pc_d;
  logic               fe_valid_q;
  logic [CNT_BITS-1:0] br_cnt_q, mis_cnt_q, drop_cnt_q;

  logic               mispredict;
  logic               fifo_full, fifo_empty, fifo_pop, fifo_drop;
  logic [REC_W-1:0]   fifo_head;

  // Wrong direction, or right "taken" direction to the wrong target.
  assign mispredict = agex_valid &
                      ((agex_taken != agex_pred_taken) |
                       (agex_taken & agex_pred_taken & (agex_target != agex_pred_target)));

  // Next-PC priority: redirect > stall hold > predicted taken > sequential.
  always_comb begin
    pc_d = pc_q + DBITS'(INSTSIZE);
    if (mispredict)    pc_d = agex_taken ? agex_target : agex_pc + DBITS'(INSTSIZE);
    else if (stall_de) pc_d = pc_q;
    else if (pred_hit) pc_d = pred_target;
  end

  // Redirect FSM with fetch PC and FE-valid latch; any mispredict enters RECOVER.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= DBITS'(STARTPC);
      fe_valid_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        ST_BOOT:    state_q <= mispredict ? ST_RECOVER : ST_RUN;
        ST_RUN:     state_q <= mispredict ? ST_RECOVER : ST_RUN;
        ST_RECOVER: state_q <= mispredict ? ST_RECOVER : ST_RUN;
        default:    state_q <= ST_BOOT;
      endcase
      if (mispredict)     fe_valid_q <= 1'b0;
      else if (!stall_de) fe_valid_q <= 1'b1;
    end
  end

  assign pc_out         = pc_q;
  assign fe_valid_out   = fe_valid_q & (state_q == ST_RUN);
  assign squash_out     = mispredict & ~reset;
  assign pred_taken_out = pred_hit & ~stall_de & ~reset;

  assign upd_valid  = ~fifo_empty & ~reset;
  assign fifo_pop   = upd_valid & upd_ready;
  assign fifo_drop  = agex_valid & fifo_full & ~fifo_pop;
  assign upd_pc     = reset ? '0 : fifo_head[REC_W-1 -: DBITS];
  assign upd_taken  = reset ? 1'b0 : fifo_head[DBITS];
  assign upd_target = reset ? '0 : fifo_head[DBITS-1:0];

  bp_upd_fifo #(
    .WIDTH (REC_W),
    .DEPTH (UPDQ_DEPTH)
  ) u_upd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (agex_valid),
    .data_i  ({agex_pc, agex_taken, agex_target}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Saturating perf counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q   <= '0;
      mis_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (agex_valid && (br_cnt_q != {CNT_BITS{1'b1}}))   br_cnt_q   <= br_cnt_q + 1'b1;
      if (mispredict && (mis_cnt_q != {CNT_BITS{1'b1}}))  mis_cnt_q  <= mis_cnt_q + 1'b1;
      if (fifo_drop && (drop_cnt_q != {CNT_BITS{1'b1}}))  drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign br_count       = br_cnt_q;
  assign mispred_count  = mis_cnt_q;
  assign upd_drop_count = drop_cnt_q;

endmodule
